// File: rtl/cache_flush_engine_pkg.sv
// Shared system-cache geometry, flush state encoding and flush-count helper
// for the cache flush engine.
package cache_flush_engine_pkg;

  localparam int unsigned SYSTEM_CACHE_NUM_WAYS      = 4;
  localparam int unsigned SYSTEM_CACHE_SIZE          = 65536;
  localparam int unsigned SYSTEM_CACHE_LINE_SIZE_LOG = 6;
  localparam int unsigned CACHE_BACKEND_ADDR_W       = 32;

  localparam int unsigned SYSTEM_CACHE_WAY_LOG   = $clog2(SYSTEM_CACHE_NUM_WAYS);
  localparam int unsigned SYSTEM_CACHE_WAY_SHIFT = SYSTEM_CACHE_LINE_SIZE_LOG;
  localparam int unsigned SYSTEM_CACHE_SET_SHIFT = SYSTEM_CACHE_LINE_SIZE_LOG + SYSTEM_CACHE_WAY_LOG;
  localparam int unsigned SYSTEM_CACHE_COUNT     =
    SYSTEM_CACHE_NUM_WAYS * (SYSTEM_CACHE_SIZE >> SYSTEM_CACHE_SET_SHIFT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cache_flush_state_t;

  function automatic int unsigned flush_count(input int unsigned ways,
                                              input int unsigned size,
                                              input int unsigned line_log);
    return ways * (size >> (line_log + $clog2(ways)));
  endfunction

endpackage

// File: rtl/cache_flush_outstanding_counter.sv
// In-flight read tracker: counts accepted requests minus accepted responses,
// never underflowing on a response that arrives with nothing outstanding.
module cache_flush_outstanding_counter #(
  parameter int unsigned MAX   = 16,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_ok;

  always_comb begin
    dec_ok  = dec && (count_q != '0);
    count_d = count_q;
    if (inc && !dec_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!inc && dec_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // full/empty describe the value after this edge so the caller can register
  // decisions without a one-cycle lag.
  assign count = count_q;
  assign full  = (count_d == CNT_W'(MAX));
  assign empty = (count_d == '0);

endmodule

// File: rtl/cache_flush_engine.sv
// Walks every line of the system cache, issuing one flush read per line
// with a bounded number in flight, then drains responses and pulses done.
module cache_flush_engine
  import cache_flush_engine_pkg::*;
#(
  parameter int unsigned NUM_WAYS        = SYSTEM_CACHE_NUM_WAYS,
  parameter int unsigned CACHE_SIZE      = SYSTEM_CACHE_SIZE,
  parameter int unsigned LINE_SIZE_LOG   = SYSTEM_CACHE_LINE_SIZE_LOG,
  parameter int unsigned ADDR_W          = CACHE_BACKEND_ADDR_W,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              flush_start,
  input  logic [ADDR_W-1:0] flush_base_addr,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              flush_error,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  output logic              resp_ready
);

  localparam int unsigned WAY_LOG   = $clog2(NUM_WAYS);
  localparam int unsigned SET_SHIFT = LINE_SIZE_LOG + WAY_LOG;
  localparam int unsigned COUNT     = flush_count(NUM_WAYS, CACHE_SIZE, LINE_SIZE_LOG);
  localparam int unsigned CNT_W     = $clog2(COUNT) + 1;
  localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING + 1);

  cache_flush_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               req_valid_q, req_valid_d;
  logic               resp_ready_q, resp_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               req_fire, resp_fire, spurious;
  logic [OUT_W-1:0]   out_count;
  logic               out_full, out_empty;

  // Set index goes above the way bits, way index into the line-offset slot.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  cnt);
    logic [ADDR_W-1:0] set_idx;
    logic [ADDR_W-1:0] way_idx;
    set_idx = ADDR_W'(cnt >> WAY_LOG);
    way_idx = ADDR_W'(cnt & CNT_W'(NUM_WAYS - 1));
    return base + ((set_idx << SET_SHIFT) | (way_idx << LINE_SIZE_LOG));
  endfunction

  assign req_fire  = req_valid_q && req_ready;
  assign resp_fire = resp_valid && resp_ready_q;
  assign spurious  = resp_fire && (out_count == '0);

  cache_flush_outstanding_counter #(
    .MAX   (MAX_OUTSTANDING),
    .CNT_W (OUT_W)
  ) u_outstanding (
    .clk   (ap_clk),
    .rst   (areset),
    .inc   (req_fire),
    .dec   (resp_fire),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    resp_ready_d = resp_ready_q;
    done_d       = 1'b0;
    error_d      = error_q | spurious;

    unique case (state_q)
      IDLE: begin
        if (flush_start) begin
          state_d      = ISSUE;
          base_d       = flush_base_addr;
          cnt_d        = '0;
          error_d      = 1'b0;
          resp_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        if (req_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (req_fire && (cnt_q == CNT_W'(COUNT - 1))) begin
          state_d     = DRAIN;
          req_valid_d = 1'b0;
        end else if (!(req_valid_q && !req_ready)) begin
          // A stalled request keeps both valid and address untouched.
          req_valid_d = !out_full;
          req_addr_d  = line_addr(base_q, cnt_d);
        end
      end
      DRAIN: begin
        if (out_empty) begin
          state_d      = DONE;
          resp_ready_d = 1'b0;
          done_d       = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      resp_ready_q <= resp_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign flush_busy  = busy_q;
  assign flush_done  = done_q;
  assign flush_error = error_q;
  assign req_valid   = req_valid_q;
  assign req_addr    = req_addr_q;
  assign resp_ready  = resp_ready_q;

endmodule

// File: tb/tb_cache_flush_engine.sv
// Directed bench for cache_flush_engine at the default 4-way, 64 KiB,
// 64-byte-line geometry with a one-cycle-latency responder model.
module tb_cache_flush_engine;

  localparam int COUNT  = 1024;
  localparam int BUDGET = 3000;

  logic        ap_clk;
  logic        areset;
  logic        flush_start;
  logic [31:0] flush_base_addr;
  logic        flush_busy;
  logic        flush_done;
  logic        flush_error;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;

  int n_checks = 0;
  int n_pass   = 0;

  int          issued, pend, done_cnt, addr_errs, stall_errs;
  logic [31:0] exp_base, stall_addr, last_addr;
  bit          auto_resp, toggle_ready, stall_pending;

  cache_flush_engine #(
    .NUM_WAYS        (4),
    .CACHE_SIZE      (65536),
    .LINE_SIZE_LOG   (6),
    .ADDR_W          (32),
    .MAX_OUTSTANDING (16)
  ) dut (
    .ap_clk          (ap_clk),
    .areset          (areset),
    .flush_start     (flush_start),
    .flush_base_addr (flush_base_addr),
    .flush_busy      (flush_busy),
    .flush_done      (flush_done),
    .flush_error     (flush_error),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge: drives this cycle's inputs, scores the handshakes
  // that the next posedge will take, then advances to the following negedge.
  task automatic cycle();
    if (toggle_ready) req_ready = ~req_ready;
    if (auto_resp) resp_valid = (pend > 0);
    if (stall_pending && !(req_valid && req_addr === stall_addr)) stall_errs++;
    stall_pending = req_valid && !req_ready;
    stall_addr    = req_addr;
    if (req_valid && req_ready) begin
      if (req_addr !== exp_base + 32'(issued) * 32'h40) addr_errs++;
      last_addr = req_addr;
      issued++;
    end
    if (resp_valid && resp_ready && pend > 0) pend--;
    if (req_valid && req_ready) pend++;
    if (flush_done) done_cnt++;
    @(negedge ap_clk);
  endtask

  task automatic start_flush(input logic [31:0] base);
    flush_start     = 1'b1;
    flush_base_addr = base;
    exp_base        = base;
    issued          = 0;
    done_cnt        = 0;
    addr_errs       = 0;
    stall_errs      = 0;
    stall_pending   = 0;
    cycle();
    flush_start     = 1'b0;
    check("busy_after_start", flush_busy, 1);
  endtask

  task automatic run_until_done(output int cycles);
    cycles = 0;
    while (!flush_done && cycles < BUDGET) begin
      cycle();
      cycles++;
    end
    check("done_seen", flush_done, 1);
    check("busy_with_done", flush_busy, 1);
    cycle();
    check("done_one_cycle", flush_done, 0);
    check("busy_after_done", flush_busy, 0);
  endtask

  initial begin
    int lat;
    int guard;
    bit saw_valid;

    areset = 1'b1; flush_start = 1'b0; flush_base_addr = '0;
    req_ready = 1'b1; resp_valid = 1'b0;
    auto_resp = 0; toggle_ready = 0; pend = 0; issued = 0; done_cnt = 0;
    addr_errs = 0; stall_errs = 0; stall_pending = 0; exp_base = '0;
    stall_addr = '0; last_addr = '0;

    repeat (2) @(negedge ap_clk);
    check("rst_ctrl_outputs", {req_valid, resp_ready, flush_busy, flush_done, flush_error}, 5'b0);
    check("rst_addr", req_addr, 0);
    areset = 1'b0;
    repeat (3) cycle();
    check("idle_no_req", req_valid, 0);
    check("idle_not_busy", flush_busy, 0);

    // Nominal run
    auto_resp = 1; req_ready = 1'b1;
    start_flush(32'h1000_0000);
    run_until_done(lat);
    check("nom_latency", lat + 1, COUNT + 3);
    check("nom_issued", issued, COUNT);
    check("nom_addr_errs", addr_errs, 0);
    check("nom_last_addr", last_addr, 32'h1000_FFC0);
    check("nom_done_pulses", done_cnt, 1);
    check("nom_no_error", flush_error, 0);

    // Backpressure: ready toggles, no responses until the cap is hit
    auto_resp = 0; resp_valid = 1'b0; req_ready = 1'b1;
    start_flush(32'h0800_0000);
    toggle_ready = 1;
    repeat (60) cycle();
    toggle_ready = 0;
    check("bp_issued_cap", issued, 16);
    check("bp_valid_dropped", req_valid, 0);
    check("bp_outstanding_16", dut.u_outstanding.count_q, 16);
    req_ready = 1'b0; resp_valid = 1'b1;
    cycle();
    check("bp_valid_reopens", req_valid, 1);
    check("bp_outstanding_15", dut.u_outstanding.count_q, 15);
    req_ready = 1'b1; resp_valid = 1'b1;
    cycle();
    check("bp_simul_req_resp", dut.u_outstanding.count_q, 15);
    check("bp_simul_issued", issued, 17);
    auto_resp = 1;
    run_until_done(lat);
    check("bp_issued_total", issued, COUNT);
    check("bp_addr_errs", addr_errs, 0);
    check("bp_stall_errs", stall_errs, 0);
    check("bp_done_pulses", done_cnt, 1);

    // Spurious response: ignored in IDLE, flagged at zero outstanding
    auto_resp = 0; resp_valid = 1'b1;
    repeat (2) cycle();
    check("spur_idle_ignored", flush_error, 0);
    start_flush(32'h2000_0000);
    cycle();
    check("spur_error_set", flush_error, 1);
    check("spur_no_underflow", dut.u_outstanding.count_q, 0);
    resp_valid = 1'b0; auto_resp = 1;
    run_until_done(lat);
    check("spur_issued_total", issued, COUNT);
    check("spur_error_sticky", flush_error, 1);

    // Reset mid-flush at cnt = 500
    start_flush(32'h3000_0000);
    check("start_clears_error", flush_error, 0);
    guard = 0;
    while (issued < 500 && guard < 1000) begin
      cycle();
      guard++;
    end
    check("rst_mid_cnt_500", dut.cnt_q, 500);
    areset = 1'b1;
    #1;
    check("rst_mid_ctrl", {req_valid, resp_ready, flush_busy, flush_done, flush_error}, 5'b0);
    check("rst_mid_addr", req_addr, 0);
    check("rst_mid_outstanding", dut.u_outstanding.count_q, 0);
    check("rst_mid_cnt", dut.cnt_q, 0);
    @(negedge ap_clk);
    areset = 1'b0; stall_pending = 0;
    auto_resp = 0; pend = 0; resp_valid = 1'b1; saw_valid = 0;
    repeat (5) begin
      cycle();
      if (req_valid) saw_valid = 1;
    end
    check("rst_no_issue", saw_valid, 0);
    check("rst_late_resp_ignored", flush_error, 0);
    resp_valid = 1'b0; auto_resp = 1;
    start_flush(32'h0000_0000);
    cycle();
    check("rst_restart_addr", {req_valid, req_addr}, {1'b1, 32'h0000_0000});
    run_until_done(lat);
    check("rst_restart_issued", issued, COUNT);
    check("rst_restart_addr_errs", addr_errs, 0);

    // Address wrap-around
    start_flush(32'hFFFF_FF80);
    cycle();
    check("wrap_addr0", req_addr, 32'hFFFF_FF80);
    cycle();
    check("wrap_addr1", req_addr, 32'hFFFF_FFC0);
    cycle();
    check("wrap_addr2", req_addr, 32'h0000_0000);
    cycle();
    check("wrap_addr3", req_addr, 32'h0000_0040);
    run_until_done(lat);
    check("wrap_issued", issued, COUNT);
    check("wrap_addr_errs", addr_errs, 0);

    // Start while busy is ignored
    start_flush(32'h4000_0000);
    repeat (10) cycle();
    flush_start = 1'b1; flush_base_addr = 32'h5000_0000;
    cycle();
    flush_start = 1'b0;
    run_until_done(lat);
    check("busy_start_addr_errs", addr_errs, 0);
    check("busy_start_issued", issued, COUNT);
    repeat (3) cycle();
    check("busy_start_done_pulses", done_cnt, 1);
    check("busy_start_idle", flush_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
